// File: rtl/demux18_sched.sv
// Break-before-make sequencer for a 1-to-8 demux: queues {sel, data} requests in a FIFO and
// walks each one through SETUP / DRIVE / GAP so a line is only driven while its select is stable.
module demux18_sched #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLD  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [2:0]               in_sel,
   input  logic                     in_data,
   output logic                     in_ready,
   output logic [3:0]               demux_i,
   output logic                     busy,
   output logic                     done,
   output logic [2:0]               done_sel,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StIdle, StSetup, StDrive, StGap} state_e;

   state_e          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [2:0]      cur_sel_q, cur_sel_d;
   logic            cur_data_q, cur_data_d;
   logic [2:0]      done_sel_q, done_sel_d;
   logic [3:0]      mem_q [DEPTH];
   logic [3:0]      mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop, fifo_empty;

   assign fifo_empty = (count_q == '0);
   assign in_ready   = (count_q != CW'(DEPTH));
   assign push       = in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_sel_d  = cur_sel_q;
      cur_data_d = cur_data_q;
      done_sel_d = done_sel_q;
      pop        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = StSetup;
            end
         end
         StSetup: begin
            state_d = StDrive;
            cnt_d   = 8'(HOLD - 1);
         end
         StDrive: begin
            if (cnt_q == 8'd0) begin
               state_d    = StGap;
               done_sel_d = cur_sel_q;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StGap: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = StSetup;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // The select only moves on the edge into SETUP, while the data bit is still low.
      if (pop) begin
         {cur_sel_d, cur_data_d} = mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {in_sel, in_data};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         cur_sel_q  <= 3'd0;
         cur_data_q <= 1'b0;
         done_sel_q <= 3'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= 4'd0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_sel_q  <= cur_sel_d;
         cur_data_q <= cur_data_d;
         done_sel_q <= done_sel_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mem_q      <= mem_d;
      end
   end

   assign demux_i    = {(state_q == StDrive) && cur_data_q, cur_sel_q};
   assign done       = (state_q == StGap);
   assign done_sel   = done_sel_q;
   assign busy       = (state_q != StIdle) || !fifo_empty;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_demux18_sched.sv
// Directed bench for demux18_sched: a HOLD=3 instance for the main sequences and a HOLD=1
// instance for the short-hold variant, with a monitor that logs done pulses and select glitches.
module tb_demux18_sched;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_data, in_ready, busy, done;
   logic [2:0] in_sel, done_sel, fifo_count;
   logic [3:0] demux_i;

   logic       h1_rst, h1_valid, h1_data, h1_ready, h1_busy, h1_done;
   logic [2:0] h1_sel, h1_done_sel, h1_count;
   logic [3:0] h1_demux;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int glitch_cnt = 0;
   int h1_drive_cnt = 0;
   logic [3:0] prev_demux = 4'd0;
   logic       last_rst = 1'b1;
   logic [2:0] done_q [$];
   int         done_cyc [$];

   demux18_sched #(.DEPTH(4), .HOLD(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
      .in_ready(in_ready), .demux_i(demux_i), .busy(busy), .done(done),
      .done_sel(done_sel), .fifo_count(fifo_count)
   );

   demux18_sched #(.DEPTH(4), .HOLD(1)) dut_h1 (
      .clk(clk), .rst(h1_rst), .in_valid(h1_valid), .in_sel(h1_sel), .in_data(h1_data),
      .in_ready(h1_ready), .demux_i(h1_demux), .busy(h1_busy), .done(h1_done),
      .done_sel(h1_done_sel), .fifo_count(h1_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Select must never move while the data bit is (or just was) high; reset edges are exempt.
   always @(negedge clk) begin
      if (done) begin
         done_q.push_back(done_sel);
         done_cyc.push_back(cyc);
      end
      if (!last_rst && (demux_i[2:0] != prev_demux[2:0]) && (demux_i[3] || prev_demux[3]))
         glitch_cnt++;
      if (h1_demux[3]) h1_drive_cnt++;
      prev_demux = demux_i;
      last_rst   = rst;
   end

   function automatic logic [7:0] dmx_o(input logic [3:0] v);
      return v[3] ? (8'd1 << v[2:0]) : 8'd0;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [2:0] s, input logic d);
      logic ok;
      int   k;
      in_valid = 1'b1;
      in_sel   = s;
      in_data  = d;
      k = 0;
      ok = 1'b0;
      while (!ok && k < 50) begin
         ok = in_ready;
         if (!ok) check("full_count", 32'(fifo_count), 32'd4);
         tick();
         k++;
      end
      if (!ok) check("push_timeout", 32'(ok), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic wait_dones(input int n, input int budget);
      int k = 0;
      while (done_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check("done_count", 32'(done_q.size()), 32'(n));
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         tick();
         k++;
      end
      check("idle_wait", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] seq [12];
      rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 1'b0;
      h1_rst = 1'b1; h1_valid = 1'b0; h1_sel = 3'd0; h1_data = 1'b0;
      tick(); tick();
      rst = 1'b0; h1_rst = 1'b0;

      // Reset state
      check("rst_demux", 32'(demux_i), 32'h0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_done_sel", 32'(done_sel), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);

      // Single request sel=5 data=1
      in_valid = 1'b1; in_sel = 3'd5; in_data = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_count_e0", 32'(fifo_count), 32'd1);
      check("t1_idle_demux", 32'(demux_i), 32'h0);
      tick();
      check("t1_setup", 32'(demux_i), 32'h5);
      check("t1_setup_o", 32'(dmx_o(demux_i)), 32'h00);
      check("t1_setup_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_drive", 32'(demux_i), 32'hD);
         check("t1_drive_o", 32'(dmx_o(demux_i)), 32'h20);
      end
      tick();
      check("t1_gap", 32'(demux_i), 32'h5);
      check("t1_gap_done", 32'(done), 32'd1);
      check("t1_gap_sel", 32'(done_sel), 32'd5);
      tick();
      check("t1_idle", 32'(demux_i), 32'h5);
      check("t1_idle_busy", 32'(busy), 32'd0);
      check("t1_idle_done", 32'(done), 32'd0);

      // Burst 0..7
      done_q.delete(); done_cyc.delete();
      for (int i = 0; i < 8; i++) push_req(3'(i), 1'b1);
      wait_dones(8, 100);
      for (int i = 0; i < 8 && i < done_q.size(); i++) begin
         check("burst_order", 32'(done_q[i]), 32'(i));
         if (i > 0) check("burst_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd5);
      end
      wait_idle(20);

      // data=0 transfer, sel=2
      in_valid = 1'b1; in_sel = 3'd2; in_data = 1'b0;
      tick();
      in_valid = 1'b0;
      check("t3_count", 32'(fifo_count), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_demux", 32'(demux_i), 32'h2);
      end
      tick();
      check("t3_gap_demux", 32'(demux_i), 32'h2);
      check("t3_done", 32'(done), 32'd1);
      check("t3_done_sel", 32'(done_sel), 32'd2);
      tick();
      check("t3_idle_busy", 32'(busy), 32'd0);

      // 12 requests: simultaneous push/pop at GAP, then fill past full
      done_q.delete(); done_cyc.delete();
      for (int i = 0; i < 12; i++) seq[i] = 3'((i * 5 + 3) % 8);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_sel = seq[i]; in_data = 1'(i % 2);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      check("t4_gap_done", 32'(done), 32'd1);
      check("t4_gap_count", 32'(fifo_count), 32'd3);
      in_valid = 1'b1; in_sel = seq[4]; in_data = 1'b0;
      tick();
      in_valid = 1'b0;
      check("t4_simul_count", 32'(fifo_count), 32'd3);
      for (int i = 5; i < 12; i++) push_req(seq[i], 1'(i % 2));
      wait_dones(12, 200);
      for (int i = 0; i < 12 && i < done_q.size(); i++)
         check("wrap_order", 32'(done_q[i]), 32'(seq[i]));
      wait_idle(20);

      // Reset in the 2nd DRIVE cycle with two requests queued
      done_q.delete(); done_cyc.delete();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_sel = 3'(i + 1); in_data = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      check("t5_queued", 32'(fifo_count), 32'd2);
      tick();
      check("t5_drive2", 32'(demux_i), 32'h9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_rst_demux", 32'(demux_i), 32'h0);
      check("t5_rst_count", 32'(fifo_count), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      repeat (10) tick();
      check("t5_no_done", 32'(done_q.size()), 32'd0);
      in_valid = 1'b1; in_sel = 3'd6; in_data = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("t5_setup", 32'(demux_i), 32'h6);
      tick();
      check("t5_drive", 32'(demux_i), 32'hE);
      check("t5_drive_o", 32'(dmx_o(demux_i)), 32'h40);
      tick(); tick(); tick();
      check("t5_done", 32'(done), 32'd1);
      check("t5_done_sel", 32'(done_sel), 32'd6);
      tick();

      // HOLD=1 variant
      h1_valid = 1'b1; h1_sel = 3'd3; h1_data = 1'b1;
      tick();
      h1_valid = 1'b0;
      tick();
      check("h1_setup", 32'(h1_demux), 32'h3);
      tick();
      check("h1_drive", 32'(h1_demux), 32'hB);
      tick();
      check("h1_gap", 32'(h1_demux), 32'h3);
      check("h1_done", 32'(h1_done), 32'd1);
      check("h1_done_sel", 32'(h1_done_sel), 32'd3);
      tick();
      check("h1_idle_busy", 32'(h1_busy), 32'd0);
      check("h1_drive_cycles", 32'(h1_drive_cnt), 32'd1);

      check("select_glitch", 32'(glitch_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
